// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter
// Shares one SPI bus (MOSI, SCLK, MISO) between two SPI master clients
// (client 0 = MAX7317 I/O expander driver, client 1 = second SPI client).
// Each client owns its chip select; csn[i] is routed to pin i only while
// client i holds the bus.
//
// Optional feature: define SPI_ARB_WATCHDOG_EN to build an ownership
// watchdog that limits a single ownership to WD_LIMIT cycles.
//
// Parameters
//   GAP_CYCLES  idle cycles enforced between successive owners (1-15)
//   WD_LIMIT    max consecutive owned cycles (16-65535, watchdog only)
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   busy[1:0]           this_busy from client i (bus request/hold)
//   other_busy[1:0]     1 = client i must not drive the bus
//   cli_mosi/sclk/csn   per-client SPI outputs
//   cli_miso[1:0]       MISO fan-out, only the current/granted client sees it
//   miso                shared MISO pin
//   mosi, sclk          shared bus pins
//   csn[1:0]            per-chip select pins, active low
//   owner[1:0]          {valid, index} of the current owner
//   wd_clear, wd_error  watchdog sticky flag and its clear
//   fsm_state[1:0]      debug view of the arbiter state
//
// Handshake: a client raises busy[i] to request the bus and keeps it high
// for the whole transfer. It may drive the pins only while other_busy[i]
// is 0; in IDLE the granted client's pins pass through combinationally, so
// a client may start in the same cycle it sees other_busy[i] = 0. Dropping
// busy[i] ends the ownership; the bus then idles GAP_CYCLES cycles.
module spi_bus_arbiter #(
  parameter int GAP_CYCLES = 2,
  parameter int WD_LIMIT   = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] busy,
  output logic [1:0] other_busy,
  input  logic [1:0] cli_mosi,
  input  logic [1:0] cli_sclk,
  input  logic [1:0] cli_csn,
  output logic [1:0] cli_miso,
  input  logic       miso,
  output logic       mosi,
  output logic       sclk,
  output logic [1:0] csn,
  output logic [1:0] owner,
  input  logic       wd_clear,
  output logic       wd_error,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t     state, state_next;
  logic       prio;      // client that wins the next simultaneous request
  logic [1:0] lock;      // client denied until its busy falls
  logic [3:0] gap_cnt;
  logic [1:0] req;
  logic       grant0, grant1;
  logic       trip;

  // A locked client is invisible to arbitration until it drops busy.
  assign req    = busy & ~lock;
  assign grant0 = req[0] & (~req[1] | ~prio);
  assign grant1 = req[1] & (~req[0] |  prio);

`ifdef SPI_ARB_WATCHDOG_EN
  logic [15:0] wd_cnt;

  assign trip = ((state == OWN0) || (state == OWN1)) &&
                (wd_cnt == 16'(WD_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt   <= '0;
      wd_error <= 1'b0;
    end else begin
      if ((state_next == OWN0 || state_next == OWN1) && state_next == state)
        wd_cnt <= wd_cnt + 16'd1;
      else
        wd_cnt <= '0;
      // A trip in the same cycle as a clear leaves the flag set.
      if (trip)
        wd_error <= 1'b1;
      else if (wd_clear)
        wd_error <= 1'b0;
    end
  end
`else
  logic unused_wd_clear;

  assign trip            = 1'b0;
  assign wd_error        = 1'b0;
  assign unused_wd_clear = wd_clear;
`endif

  // State register and bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      prio    <= 1'b0;
      lock    <= 2'b00;
      gap_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == GAP && state_next == GAP)
        gap_cnt <= gap_cnt + 4'd1;
      else
        gap_cnt <= '0;
      if (state == IDLE && grant0)
        prio <= 1'b1;
      else if (state == IDLE && grant1)
        prio <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (!busy[i])
          lock[i] <= 1'b0;
        else if ((state == IDLE && req[i] && (i == 0 ? grant1 : grant0)) ||
                 (trip && state == (i == 0 ? OWN0 : OWN1)))
          lock[i] <= 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant0)
          state_next = OWN0;
        else if (grant1)
          state_next = OWN1;
      end
      OWN0: if (trip || !busy[0]) state_next = GAP;
      OWN1: if (trip || !busy[1]) state_next = GAP;
      GAP:  if (gap_cnt == 4'(GAP_CYCLES - 1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: pin mux is purely combinational; reset forces the safe values.
  always_comb begin
    other_busy = 2'b11;
    csn        = 2'b11;
    sclk       = 1'b0;
    mosi       = 1'b0;
    cli_miso   = 2'b00;
    owner      = 2'b00;
    if (!reset) begin
      case (state)
        IDLE: begin
          other_busy = {grant0 | lock[1], grant1 | lock[0]};
          if (grant0) begin
            mosi        = cli_mosi[0];
            sclk        = cli_sclk[0];
            csn         = {1'b1, cli_csn[0]};
            cli_miso[0] = miso;
          end else if (grant1) begin
            mosi        = cli_mosi[1];
            sclk        = cli_sclk[1];
            csn         = {cli_csn[1], 1'b1};
            cli_miso[1] = miso;
          end
        end
        OWN0: begin
          other_busy  = 2'b10;
          mosi        = cli_mosi[0];
          sclk        = cli_sclk[0];
          csn         = {1'b1, cli_csn[0]};
          cli_miso[0] = miso;
          owner       = 2'b10;
        end
        OWN1: begin
          other_busy  = 2'b01;
          mosi        = cli_mosi[1];
          sclk        = cli_sclk[1];
          csn         = {cli_csn[1], 1'b1};
          cli_miso[1] = miso;
          owner       = 2'b11;
        end
        default: ;
      endcase
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed testbench for spi_bus_arbiter (GAP_CYCLES = 2, WD_LIMIT = 16).
module tb_spi_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] busy;
  logic [1:0] other_busy;
  logic [1:0] cli_mosi, cli_sclk, cli_csn, cli_miso;
  logic       miso, mosi, sclk;
  logic [1:0] csn, owner, fsm_state;
  logic       wd_clear, wd_error;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] exp_q[$];
  logic [15:0] rx;
  int          rx_bits = 0;
  bit          mon_en  = 1'b0;
  int          overlap = 0;

  localparam logic [1:0] S_IDLE = 2'd0, S_OWN0 = 2'd1, S_OWN1 = 2'd2, S_GAP = 2'd3;

  // clock / reset block
  always #5 clk = ~clk;

  spi_bus_arbiter #(.GAP_CYCLES(2), .WD_LIMIT(16)) dut (
    .clk(clk), .reset(reset), .busy(busy), .other_busy(other_busy),
    .cli_mosi(cli_mosi), .cli_sclk(cli_sclk), .cli_csn(cli_csn),
    .cli_miso(cli_miso), .miso(miso), .mosi(mosi), .sclk(sclk), .csn(csn),
    .owner(owner), .wd_clear(wd_clear), .wd_error(wd_error),
    .fsm_state(fsm_state)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wait_owner(input logic [1:0] exp, input string tag);
    int n = 0;
    while (owner !== exp && n < 50) begin
      tick();
      n++;
    end
    check(tag, owner, exp);
  endtask

  // Client 0 bit-bangs a 16-bit MSB-first frame; client 1 drives inverted
  // junk on its own pins, which must never reach the bus.
  task automatic send_frame(input logic [15:0] f);
    exp_q.push_back(f);
    cli_csn[0] = 1'b0;
    tick();
    for (int i = 15; i >= 0; i--) begin
      cli_mosi = {~f[i], f[i]};
      cli_sclk = 2'b10;
      tick();
      cli_sclk = 2'b01;
      tick();
    end
    cli_sclk = 2'b00;
    tick();
    cli_csn[0] = 1'b1;
    tick();
  endtask

  // scoreboard: capture pin traffic for chip 0
  always @(posedge sclk) begin
    if (mon_en && csn[0] === 1'b0) begin
      rx = {rx[14:0], mosi};
      rx_bits++;
    end
  end

  always @(posedge csn[0]) begin
    if (mon_en && rx_bits > 0) begin
      check("frame_len", 16'(rx_bits), 16'd16);
      if (exp_q.size() > 0) check("frame", rx, exp_q.pop_front());
      else check("frame_unexpected", rx, 16'hxxxx);
      rx_bits = 0;
    end
  end

  always @(negedge clk) if (csn == 2'b00) overlap++;

  initial begin
    reset = 1'b1; busy = 2'b11; cli_csn = 2'b00; cli_sclk = 2'b11;
    cli_mosi = 2'b11; miso = 1'b0; wd_clear = 1'b0;
    settle();
    check("rst_csn", csn, 2'b11);
    check("rst_other_busy", other_busy, 2'b11);
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    tick(); tick();
    check("rst_state", fsm_state, S_IDLE);
    check("rst_owner", owner, 2'b00);
    check("rst_wd_error", wd_error, 1'b0);
    busy = 2'b00; cli_csn = 2'b11; cli_sclk = 2'b00; cli_mosi = 2'b00;
    reset = 1'b0;
    tick();
    check("idle_other_busy", other_busy, 2'b00);
    check("idle_csn", csn, 2'b11);

    // single owner, client 0, then gap
    busy = 2'b01; cli_csn = 2'b10; cli_mosi = 2'b01; cli_sclk = 2'b01; miso = 1'b1;
    settle();
    check("a_idle_csn", csn, 2'b10);
    check("a_idle_mosi", mosi, 1'b1);
    check("a_idle_sclk", sclk, 1'b1);
    check("a_idle_other_busy", other_busy, 2'b10);
    check("a_idle_cli_miso", cli_miso, 2'b01);
    check("a_idle_owner", owner, 2'b00);
    tick();
    check("a_own_owner", owner, 2'b10);
    check("a_own_other_busy", other_busy, 2'b10);
    cli_mosi = 2'b00;
    settle();
    check("a_own_mosi_passthru", mosi, 1'b0);
    repeat (33) tick();
    check("a_own_hold", fsm_state, S_OWN0);
    busy = 2'b00;
    tick();
    check("a_gap1_state", fsm_state, S_GAP);
    check("a_gap1_other_busy", other_busy, 2'b11);
    check("a_gap1_csn", csn, 2'b11);
    check("a_gap1_owner", owner, 2'b00);
    tick();
    check("a_gap2_state", fsm_state, S_GAP);
    check("a_gap2_other_busy", other_busy, 2'b11);
    tick();
    check("a_end_state", fsm_state, S_IDLE);
    check("a_end_other_busy", other_busy, 2'b00);

    // simultaneous requests, round robin and loser lockout
    reset = 1'b1; tick(); reset = 1'b0;
    busy = 2'b11; cli_csn = 2'b00; cli_mosi = 2'b10; cli_sclk = 2'b10;
    settle();
    check("b_tie_csn", csn, 2'b10);
    check("b_tie_mosi", mosi, 1'b0);
    check("b_tie_sclk", sclk, 1'b0);
    check("b_tie_other_busy", other_busy, 2'b10);
    check("b_tie_cli_miso", cli_miso, 2'b01);
    tick();
    check("b_own0", owner, 2'b10);
    busy = 2'b10;
    tick(); tick(); tick();
    check("b_after_gap_state", fsm_state, S_IDLE);
    check("b_locked_other_busy", other_busy, 2'b10);
    check("b_locked_csn", csn, 2'b11);
    busy = 2'b00;
    tick();
    busy = 2'b11;
    settle();
    check("b_tie2_csn", csn, 2'b01);
    check("b_tie2_mosi", mosi, 1'b1);
    check("b_tie2_other_busy", other_busy, 2'b01);
    check("b_tie2_cli_miso", cli_miso, 2'b10);
    tick();
    check("b_own1", owner, 2'b11);

    // client 0 activity while client 1 owns the bus is ignored
    cli_sclk = 2'b01;
    settle();
    check("c_sclk_lo", sclk, 1'b0);
    check("c_csn", csn, 2'b01);
    cli_sclk = 2'b10;
    settle();
    check("c_sclk_hi", sclk, 1'b1);
    busy = 2'b10; tick();
    busy = 2'b11; tick();
    check("c_csn_after_edge", csn, 2'b01);
    check("c_other_busy", other_busy, 2'b01);
    check("c_owner", owner, 2'b11);
    busy = 2'b01;
    tick(); tick(); tick();
    check("c_idle_grant0_csn", csn, 2'b10);
    busy = 2'b00;
    tick();

    // reset in the middle of a transfer
    busy = 2'b01; cli_csn = 2'b10; cli_sclk = 2'b01; cli_mosi = 2'b01;
    tick();
    repeat (9) tick();
    check("d_pre_owner", owner, 2'b10);
    reset = 1'b1;
    settle();
    check("d_rst_csn", csn, 2'b11);
    check("d_rst_other_busy", other_busy, 2'b11);
    check("d_rst_sclk", sclk, 1'b0);
    check("d_rst_owner", owner, 2'b00);
    tick();
    reset = 1'b0; busy = 2'b00;
    tick();
    check("d_post_state", fsm_state, S_IDLE);
    check("d_post_owner", owner, 2'b00);

`ifdef SPI_ARB_WATCHDOG_EN
    busy = 2'b01;
    tick();
    repeat (15) tick();
    check("wd_still_own", owner, 2'b10);
    wd_clear = 1'b1;
    tick();
    wd_clear = 1'b0;
    check("wd_trip_owner", owner, 2'b00);
    check("wd_trip_state", fsm_state, S_GAP);
    check("wd_trip_error", wd_error, 1'b1);
    check("wd_trip_csn", csn, 2'b11);
    tick(); tick();
    check("wd_locked_csn", csn, 2'b11);
    check("wd_locked_other_busy", other_busy, 2'b01);
    wd_clear = 1'b1;
    tick();
    wd_clear = 1'b0;
    check("wd_cleared", wd_error, 1'b0);
    busy = 2'b00;
    tick();
`endif

    // MAX7317 writes against a busy client 1
    cli_csn = 2'b01; cli_sclk = 2'b00; cli_mosi = 2'b00; mon_en = 1'b1;
    busy = 2'b01;
    tick();
    wait_owner(2'b10, "e_own0_first");
    busy = 2'b11;
    send_frame(16'hA5C3);
    busy = 2'b10;
    wait_owner(2'b11, "e_own1");
    tick(); tick();
    busy = 2'b11;
    tick();
    busy = 2'b01;
    wait_owner(2'b10, "e_own0_second");
    send_frame(16'h1234);
    busy = 2'b00;
    tick(); tick(); tick(); tick();
    check("e_queue_empty", 16'(exp_q.size()), 16'd0);
    check("e_csn_overlap", 16'(overlap), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_bus_arbiter.md
SPI_BUS_ARBITER -- requirements
Module: spi_bus_arbiter

Interface
REQ-001 Parameter GAP_CYCLES, default 2: idle cycles enforced between successive bus owners, legal range 1-15.
REQ-002 Parameter WD_LIMIT, default 255: maximum consecutive cycles a client may own the bus, legal range 16-65535; used only when SPI_ARB_WATCHDOG_EN is defined.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 busy  input  2  this_busy from client i (bit 0 = MAX7317 I/O expander, bit 1 = second SPI client).
REQ-006 other_busy  output  2  bit i is the other_busy to client i; 1 means client i must not drive the bus.
REQ-007 cli_mosi  input  2  MOSI from client i.
REQ-008 cli_sclk  input  2  SCLK from client i.
REQ-009 cli_csn  input  2  CSn from client i.
REQ-010 cli_miso  output  2  MISO fan-out to client i.
REQ-011 miso  input  1  shared MISO pin.
REQ-012 mosi  output  1  shared MOSI pin.
REQ-013 sclk  output  1  shared SCLK pin.
REQ-014 csn  output  2  per-chip CSn pins, active low.
REQ-015 owner  output  2  status {valid, index} of the current owner.
REQ-016 wd_clear  input  1  clears wd_error.
REQ-017 wd_error  output  1  sticky watchdog-trip flag.

Function
REQ-018 The block SHALL implement four states: IDLE, OWN0, OWN1, GAP.
REQ-019 IDLE: other_busy[i] SHALL be 1 only when busy[j] is 1 and busy[i] is 0, or when both are 1 and prio selects j (j = 1-i).
REQ-020 IDLE -> OWNi on the edge where busy[i] is 1 and either busy[j] is 0 or prio = i.
REQ-021 Simultaneous requests SHALL be resolved round-robin: prio resets to 0 and toggles to the non-winner on every grant.
REQ-022 OWNi: other_busy[j] SHALL be 1 and other_busy[i] SHALL be 0; OWNi -> GAP on the edge where busy[i] is sampled 0.
REQ-023 GAP: both other_busy bits SHALL be 1 for exactly GAP_CYCLES cycles, then the state SHALL return to IDLE.
REQ-024 Pin muxing SHALL be combinational, with zero-cycle latency from client to pin.
REQ-025 In OWNi: mosi = cli_mosi[i], sclk = cli_sclk[i], csn[i] = cli_csn[i], csn[j] = 1.
REQ-026 In IDLE: pins SHALL follow the requesting client combinationally. If both clients request, pins SHALL follow the prio winner and the loser's csn SHALL be forced to 1.
REQ-027 In GAP, and in IDLE with no request: csn = 2'b11, sclk = 0, mosi = 0.
REQ-028 cli_miso[i] SHALL equal miso when client i is current or granted, else 0.
REQ-029 owner SHALL be {1, i} in OWNi and 2'b00 otherwise.
REQ-030 A losing client that asserted busy in the same cycle SHALL be denied (csn held high, other_busy high) until it deasserts busy and re-requests after GAP.
REQ-031 A busy[j] edge occurring while the state is OWNi SHALL be ignored; no pin change is permitted.

Reset
REQ-032 While reset is 1: state = IDLE, prio = 0, gap counter = 0, watchdog counter = 0, wd_error = 0, csn = 2'b11, sclk = 0, mosi = 0, other_busy = 2'b11.
REQ-033 Reset asserted mid-transfer SHALL abort the transfer immediately; after release the block SHALL start in IDLE.

Configuration
REQ-034 Macro SPI_ARB_WATCHDOG_EN defined: a 16-bit counter SHALL count cycles in OWNi.
REQ-035 With SPI_ARB_WATCHDOG_EN, on reaching WD_LIMIT the block SHALL force the state to GAP, set wd_error, and set csn high for that client until its busy falls.
REQ-036 wd_error SHALL be cleared by wd_clear; if a trip and wd_clear coincide, the set SHALL win.
REQ-037 Macro SPI_ARB_WATCHDOG_EN undefined: no counter is built, wd_error is tied to 0, wd_clear is ignored, and ownership is unlimited.

Verification
REQ-038 busy = 01 for 34 cycles, then 00 -> OWN0 on the next edge; pins follow client 0; other_busy = 10; GAP lasts 2 cycles with other_busy = 11; then IDLE.
REQ-039 busy = 11 on the same edge after reset -> client 0 wins; csn[1] = 1 and other_busy[1] = 1. On the next simultaneous request after GAP, client 1 wins.
REQ-040 In OWN1, busy[0] rises -> csn[0] stays 1, sclk tracks cli_sclk[1], and owner = 2'b11 throughout.
REQ-041 Reset pulsed at cycle 10 of an OWN0 transfer -> csn = 11, other_busy = 11 during reset, IDLE after release.
REQ-042 With SPI_ARB_WATCHDOG_EN and WD_LIMIT = 16, busy[0] held high -> after 16 cycles in OWN0: GAP, wd_error = 1, csn[0] = 1; wd_clear -> wd_error = 0.
REQ-043 MAX7317 client model with back-to-back writes against a busy client 1 -> each 16-bit frame appears intact on mosi/sclk, and no two csn bits are low in the same cycle.
